// File: rtl/countdown_mod_timer_if.sv
// Control/preset inputs and digit/status outputs of the MM:SS countdown timer.
// Strobes (tick, load, start, pause, ack) are single-cycle level samples taken on clk; there is no valid/ready backpressure.
interface countdown_mod_timer_if;
  logic       tick;
  logic       load;
  logic [2:0] ld_mt;
  logic [3:0] ld_mu;
  logic [2:0] ld_st;
  logic [3:0] ld_su;
  logic       start;
  logic       pause;
  logic       ack;
  logic [2:0] min_t;
  logic [3:0] min_u;
  logic [2:0] sec_t;
  logic [3:0] sec_u;
  logic       running;
  logic       expired;
  logic       alarm_active;
  logic [1:0] state;

  modport master (
    output tick, load, ld_mt, ld_mu, ld_st, ld_su, start, pause, ack,
    input  min_t, min_u, sec_t, sec_u, running, expired, alarm_active, state
  );

  modport slave (
    input  tick, load, ld_mt, ld_mu, ld_st, ld_su, start, pause, ack,
    output min_t, min_u, sec_t, sec_u, running, expired, alarm_active, state
  );
endinterface

// File: rtl/countdown_mod_timer.sv
// Down-counting BCD MM:SS timer with borrow chain, pause/resume and expiry alarm.
// Optional AUTO_RELOAD_EN: reload the last loaded preset at expiry and keep running.
module countdown_mod_timer #(
  parameter int MIN_TENS_MAX = 5,
  parameter int SEC_TENS_MAX = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  countdown_mod_timer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_e;

  localparam logic [2:0] MT_MAX = 3'(MIN_TENS_MAX);
  localparam logic [2:0] ST_MAX = 3'(SEC_TENS_MAX);

  state_e     state_q, state_d;
  logic [2:0] mt_q, mt_d;
  logic [3:0] mu_q, mu_d;
  logic [2:0] st_q, st_d;
  logic [3:0] su_q, su_d;
  logic       expired_q, expired_d;

  logic [2:0] ld_mt_c, ld_st_c;
  logic [3:0] ld_mu_c, ld_su_c;
  logic [2:0] mt_dec, st_dec;
  logic [3:0] mu_dec, su_dec;
  logic       borrow_su, borrow_st, borrow_mu;
  logic       at_zero, at_one;

`ifdef AUTO_RELOAD_EN
  logic [13:0] reload_q, reload_d;
`endif

  // Clamp presets so the counter never holds a non-BCD or out-of-range digit.
  always_comb begin
    ld_mt_c = (bus.ld_mt > MT_MAX) ? MT_MAX : bus.ld_mt;
    ld_st_c = (bus.ld_st > ST_MAX) ? ST_MAX : bus.ld_st;
    ld_mu_c = (bus.ld_mu > 4'd9)   ? 4'd9   : bus.ld_mu;
    ld_su_c = (bus.ld_su > 4'd9)   ? 4'd9   : bus.ld_su;
  end

  always_comb begin
    borrow_su = (su_q == 4'd0);
    su_dec    = borrow_su ? 4'd9 : su_q - 4'd1;
    borrow_st = borrow_su && (st_q == 3'd0);
    st_dec    = borrow_su ? ((st_q == 3'd0) ? ST_MAX : st_q - 3'd1) : st_q;
    borrow_mu = borrow_st && (mu_q == 4'd0);
    mu_dec    = borrow_st ? ((mu_q == 4'd0) ? 4'd9 : mu_q - 4'd1) : mu_q;
    mt_dec    = borrow_mu ? mt_q - 3'd1 : mt_q;
    at_zero   = ({mt_q, mu_q, st_q, su_q} == 14'd0);
    at_one    = ({mt_q, mu_q, st_q, su_q} == 14'd1);
  end

  always_comb begin
    state_d   = state_q;
    mt_d      = mt_q;
    mu_d      = mu_q;
    st_d      = st_q;
    su_d      = su_q;
    expired_d = 1'b0;
`ifdef AUTO_RELOAD_EN
    reload_d  = reload_q;
`endif
    if (bus.load) begin
      mt_d    = ld_mt_c;
      mu_d    = ld_mu_c;
      st_d    = ld_st_c;
      su_d    = ld_su_c;
      state_d = S_IDLE;
`ifdef AUTO_RELOAD_EN
      reload_d = {ld_mt_c, ld_mu_c, ld_st_c, ld_su_c};
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start && !at_zero) state_d = S_RUN;
        end
        S_RUN: begin
          if (bus.pause) begin
            state_d = S_PAUSE;
          end else if (bus.tick && !at_zero) begin
            if (at_one) begin
              expired_d = 1'b1;
`ifdef AUTO_RELOAD_EN
              if (reload_q != 14'd0) begin
                {mt_d, mu_d, st_d, su_d} = reload_q;
              end else begin
                {mt_d, mu_d, st_d, su_d} = 14'd0;
                state_d = S_DONE;
              end
`else
              {mt_d, mu_d, st_d, su_d} = 14'd0;
              state_d = S_DONE;
`endif
            end else begin
              mt_d = mt_dec;
              mu_d = mu_dec;
              st_d = st_dec;
              su_d = su_dec;
            end
          end
        end
        S_PAUSE: begin
          if (!bus.pause && bus.start) state_d = S_RUN;
        end
        S_DONE: begin
          if (bus.ack) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      mt_q      <= 3'd0;
      mu_q      <= 4'd0;
      st_q      <= 3'd0;
      su_q      <= 4'd0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mt_q      <= mt_d;
      mu_q      <= mu_d;
      st_q      <= st_d;
      su_q      <= su_d;
      expired_q <= expired_d;
    end
  end

`ifdef AUTO_RELOAD_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) reload_q <= 14'd0;
    else      reload_q <= reload_d;
  end
`endif

  assign bus.min_t        = mt_q;
  assign bus.min_u        = mu_q;
  assign bus.sec_t        = st_q;
  assign bus.sec_u        = su_q;
  assign bus.state        = state_q;
  assign bus.running      = (state_q == S_RUN);
  assign bus.alarm_active = (state_q == S_DONE);
  assign bus.expired      = expired_q;

endmodule

// File: tb/tb_countdown_mod_timer.sv
// Table-driven bench for countdown_mod_timer plus hand sequences for reset and async behaviour.
module tb_countdown_mod_timer;

  typedef struct {
    string       name;
    logic        ld;
    logic [13:0] preset;
    logic        start;
    logic        pause;
    logic        tick;
    logic        ack;
    logic [13:0] exp_dig;
    logic [1:0]  exp_state;
    logic        exp_expired;
  } vec_t;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  vec_t vecs[$];

  countdown_mod_timer_if bus ();

  countdown_mod_timer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [13:0] dg(input logic [2:0] a, input logic [3:0] b,
                                     input logic [2:0] c, input logic [3:0] d);
    return {a, b, c, d};
  endfunction

  task automatic add(input string name, input logic ld, input logic [13:0] preset,
                     input logic start, input logic pause, input logic tick, input logic ack,
                     input logic [13:0] exp_dig, input logic [1:0] exp_state,
                     input logic exp_expired);
    vec_t v;
    v.name = name; v.ld = ld; v.preset = preset;
    v.start = start; v.pause = pause; v.tick = tick; v.ack = ack;
    v.exp_dig = exp_dig; v.exp_state = exp_state; v.exp_expired = exp_expired;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.load = 1'b0; bus.start = 1'b0; bus.pause = 1'b0; bus.tick = 1'b0; bus.ack = 1'b0;
    bus.ld_mt = 3'd0; bus.ld_mu = 4'd0; bus.ld_st = 3'd0; bus.ld_su = 4'd0;
  endtask

  task automatic check_outputs(input string name, input logic [13:0] dig,
                               input logic [1:0] st, input logic ex);
    check({name, ".digits"}, {2'b0, bus.min_t, bus.min_u, bus.sec_t, bus.sec_u}, {2'b0, dig});
    check({name, ".state"}, {14'b0, bus.state}, {14'b0, st});
    check({name, ".expired"}, {15'b0, bus.expired}, {15'b0, ex});
    check({name, ".running"}, {15'b0, bus.running}, {15'b0, (st == 2'b01)});
    check({name, ".alarm"}, {15'b0, bus.alarm_active}, {15'b0, (st == 2'b11)});
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    bus.load = v.ld;
    {bus.ld_mt, bus.ld_mu, bus.ld_st, bus.ld_su} = v.preset;
    bus.start = v.start; bus.pause = v.pause; bus.tick = v.tick; bus.ack = v.ack;
    @(posedge clk);
    #1;
    clear_inputs();
    check_outputs(v.name, v.exp_dig, v.exp_state, v.exp_expired);
  endtask

  localparam logic [1:0] IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, DONE = 2'b11;

  initial begin
    vec_t v;
    tests = 0;
    fails = 0;
    rst = 1'b0;
    clear_inputs();

    // name, ld, preset, start, pause, tick, ack, exp digits, exp state, exp expired
    add("ld_10_00", 1, dg(1,0,0,0), 0,0,0,0, dg(1,0,0,0), IDLE, 0);
    add("idle_tick", 0, 14'd0,      0,0,1,0, dg(1,0,0,0), IDLE, 0);
    add("start_10", 0, 14'd0,       1,0,0,0, dg(1,0,0,0), RUN,  0);
    add("borrow_09_59", 0, 14'd0,   0,0,1,0, dg(0,9,5,9), RUN,  0);
    add("ld_01_00", 1, dg(0,1,0,0), 0,0,0,0, dg(0,1,0,0), IDLE, 0);
    add("start_01", 0, 14'd0,       1,0,0,0, dg(0,1,0,0), RUN,  0);
    add("borrow_00_59", 0, 14'd0,   0,0,1,0, dg(0,0,5,9), RUN,  0);
    add("start_in_run", 0, 14'd0,   1,0,0,0, dg(0,0,5,9), RUN,  0);
`ifdef AUTO_RELOAD_EN
    add("ld_00_02", 1, dg(0,0,0,2), 0,0,0,0, dg(0,0,0,2), IDLE, 0);
    add("start_02", 0, 14'd0,       1,0,0,0, dg(0,0,0,2), RUN,  0);
    add("rl_tick1", 0, 14'd0,       0,0,1,0, dg(0,0,0,1), RUN,  0);
    add("rl_reload1", 0, 14'd0,     0,0,1,0, dg(0,0,0,2), RUN,  1);
    add("rl_gap", 0, 14'd0,         0,0,0,0, dg(0,0,0,2), RUN,  0);
    add("rl_tick3", 0, 14'd0,       0,0,1,0, dg(0,0,0,1), RUN,  0);
    add("rl_reload2", 0, 14'd0,     0,0,1,0, dg(0,0,0,2), RUN,  1);
    add("rl_after", 0, 14'd0,       0,0,0,0, dg(0,0,0,2), RUN,  0);
`else
    add("ld_00_03", 1, dg(0,0,0,3), 0,0,0,0, dg(0,0,0,3), IDLE, 0);
    add("start_03", 0, 14'd0,       1,0,0,0, dg(0,0,0,3), RUN,  0);
    add("exp_tick1", 0, 14'd0,      0,0,1,0, dg(0,0,0,2), RUN,  0);
    add("exp_tick2", 0, 14'd0,      0,0,1,0, dg(0,0,0,1), RUN,  0);
    add("exp_tick3", 0, 14'd0,      0,0,1,0, 14'd0,       DONE, 1);
    add("exp_one_cycle", 0, 14'd0,  0,0,0,0, 14'd0,       DONE, 0);
    add("done_tick", 0, 14'd0,      0,0,1,0, 14'd0,       DONE, 0);
    add("done_start", 0, 14'd0,     1,1,1,0, 14'd0,       DONE, 0);
    add("done_ack", 0, 14'd0,       0,0,0,1, 14'd0,       IDLE, 0);
`endif
    add("ld_00_10", 1, dg(0,0,1,0), 0,0,0,0, dg(0,0,1,0), IDLE, 0);
    add("start_10s", 0, 14'd0,      1,0,0,0, dg(0,0,1,0), RUN,  0);
    add("pause_tick", 0, 14'd0,     0,1,1,0, dg(0,0,1,0), PAUSE, 0);
    for (int i = 0; i < 5; i++)
      add($sformatf("paused_tick%0d", i), 0, 14'd0, 0,0,1,0, dg(0,0,1,0), PAUSE, 0);
    add("resume", 0, 14'd0,         1,0,0,0, dg(0,0,1,0), RUN,  0);
    add("resume_tick", 0, 14'd0,    0,0,1,0, dg(0,0,0,9), RUN,  0);
    add("clamp", 1, dg(7,12,6,15),  0,0,0,0, dg(5,9,5,9), IDLE, 0);
    add("start_59", 0, 14'd0,       1,0,0,0, dg(5,9,5,9), RUN,  0);
    add("tick_59_58", 0, 14'd0,     0,0,1,0, dg(5,9,5,8), RUN,  0);
    add("ld_in_run", 1, dg(2,0,0,0), 1,1,1,0, dg(2,0,0,0), IDLE, 0);
    add("ld_00_00", 1, 14'd0,       0,0,0,0, 14'd0,       IDLE, 0);
    add("start_zero", 0, 14'd0,     1,0,0,0, 14'd0,       IDLE, 0);
    add("zero_tick", 0, 14'd0,      0,0,1,0, 14'd0,       IDLE, 0);

    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset", 14'd0, IDLE, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) apply(vecs[i]);

    // Asynchronous reset in the middle of a running count with a tick pending.
    v = '{"ar_ld", 1, dg(1,2,3,4), 0,0,0,0, dg(1,2,3,4), IDLE, 0};
    apply(v);
    v = '{"ar_start", 0, 14'd0, 1,0,0,0, dg(1,2,3,4), RUN, 0};
    apply(v);
    @(negedge clk);
    bus.tick = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check_outputs("async_rst", 14'd0, IDLE, 1'b0);
    @(posedge clk);
    #1;
    check_outputs("rst_held", 14'd0, IDLE, 1'b0);
    @(negedge clk);
    bus.tick = 1'b0;
    rst = 1'b1;
    v = '{"post_rst_tick", 0, 14'd0, 0,0,1,0, 14'd0, IDLE, 0};
    apply(v);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
